// File: rtl/regfile_alu_pipe.sv
// regfile_alu_pipe: two-stage execution unit with a WIDTH x DEPTH register file,
// eight-operation ALU, immediate operand select, writeback and operand forwarding.
// Stage R holds captured operands, stage X holds the ALU result presented on out_*.
// Optional feature: define REGFILE_ZERO_REG_EN to hardwire reg[0] to zero.
module regfile_alu_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned SW = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rs2,
  input  logic [AW-1:0]    in_rd,
  input  logic             in_use_imm,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_we,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [AW-1:0]    out_rd,
  output logic             out_zero,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpSll = 3'b010,
    OpSrl = 3'b011,
    OpSra = 3'b100,
    OpAnd = 3'b101,
    OpOr  = 3'b110,
    OpXor = 3'b111
  } alu_op_e;

  logic [WIDTH-1:0] rf [DEPTH];

  // Stage R
  logic             r_valid;
  logic [2:0]       r_op;
  logic [AW-1:0]    r_rd;
  logic             r_we;
  logic [WIDTH-1:0] r_a, r_b;

  // Stage X
  logic             x_valid;
  logic [AW-1:0]    x_rd;
  logic             x_we;
  logic [WIDTH-1:0] x_result;

  logic             stall, accept, retire, rf_wr;
  logic             fwd_r, fwd_x;
  logic [WIDTH-1:0] alu_y, rf_a, rf_b, op_a, op_b;
  logic [SW-1:0]    shamt;

  assign stall    = x_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;
  assign retire   = x_valid && out_ready;

  assign out_valid  = x_valid;
  assign out_result = x_result;
  assign out_rd     = x_rd;
  assign out_zero   = x_valid && (x_result == '0);

  // ALU on the operands held in stage R
  always_comb begin
    shamt = r_b[SW-1:0];
    alu_y = '0;
    unique case (alu_op_e'(r_op))
      OpAdd:   alu_y = r_a + r_b;
      OpSub:   alu_y = r_a - r_b;
      OpSll:   alu_y = r_a << shamt;
      OpSrl:   alu_y = r_a >> shamt;
      OpSra:   alu_y = $unsigned($signed(r_a) >>> shamt);
      OpAnd:   alu_y = r_a & r_b;
      OpOr:    alu_y = r_a | r_b;
      OpXor:   alu_y = r_a ^ r_b;
      default: alu_y = '0;
    endcase
  end

  // Operand fetch with forwarding: R result first, then X result, then array
  always_comb begin
    rf_a  = rf[in_rs1];
    rf_b  = rf[in_rs2];
    fwd_r = r_valid && !stall && r_we;
    fwd_x = x_valid && x_we;
    rf_wr = retire && x_we;
`ifdef REGFILE_ZERO_REG_EN
    if (in_rs1 == '0) rf_a = '0;
    if (in_rs2 == '0) rf_b = '0;
    fwd_r = fwd_r && (r_rd != '0);
    fwd_x = fwd_x && (x_rd != '0);
    rf_wr = rf_wr && (x_rd != '0);
`endif
    if (fwd_r && (r_rd == in_rs1))      op_a = alu_y;
    else if (fwd_x && (x_rd == in_rs1)) op_a = x_result;
    else                                op_a = rf_a;
    if (in_use_imm)                     op_b = in_imm;
    else if (fwd_r && (r_rd == in_rs2)) op_b = alu_y;
    else if (fwd_x && (x_rd == in_rs2)) op_b = x_result;
    else                                op_b = rf_b;
  end

  // Debug read port, straight from the array
  always_comb begin
    dbg_data = rf[dbg_addr];
`ifdef REGFILE_ZERO_REG_EN
    if (dbg_addr == '0) dbg_data = '0;
`endif
  end

  // Pipeline registers; both stages freeze while the output is back-pressured
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid  <= 1'b0;
      r_op     <= '0;
      r_rd     <= '0;
      r_we     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      x_valid  <= 1'b0;
      x_rd     <= '0;
      x_we     <= 1'b0;
      x_result <= '0;
    end else if (!stall) begin
      r_valid <= accept;
      if (accept) begin
        r_op <= in_op;
        r_rd <= in_rd;
        r_we <= in_we;
        r_a  <= op_a;
        r_b  <= op_b;
      end
      x_valid <= r_valid;
      if (r_valid) begin
        x_rd     <= r_rd;
        x_we     <= r_we;
        x_result <= alu_y;
      end
    end
  end

  // Register file writeback at retirement
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(DEPTH); i++) rf[i] <= '0;
    end else if (rf_wr) begin
      rf[x_rd] <= x_result;
    end
  end

endmodule

// File: tb/tb_regfile_alu_pipe.sv
// Directed self-checking bench for regfile_alu_pipe (WIDTH=32, DEPTH=32).
// Honours REGFILE_ZERO_REG_EN for the reg[0] expectations.
module tb_regfile_alu_pipe;

  localparam int unsigned AW = 5;

  logic          CLK = 1'b0;
  logic          RST;
  logic          in_valid, in_ready, in_use_imm, in_we;
  logic [2:0]    in_op;
  logic [AW-1:0] in_rs1, in_rs2, in_rd, out_rd, dbg_addr;
  logic [31:0]   in_imm, out_result, dbg_data;
  logic          out_valid, out_ready, out_zero;

  int checks = 0;
  int errors = 0;

  regfile_alu_pipe #(.WIDTH(32), .DEPTH(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_rd      (in_rd),
    .in_use_imm (in_use_imm),
    .in_imm     (in_imm),
    .in_we      (in_we),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_zero   (out_zero),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic dbg(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic send(input logic [2:0] op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                      input logic [AW-1:0] rd, input logic use_imm, input logic [31:0] imm);
    in_valid   = 1'b1;
    in_op      = op;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_rd      = rd;
    in_use_imm = use_imm;
    in_imm     = imm;
    in_we      = 1'b1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_we    = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_r4, exp_r0;
    RST = 1'b1; out_ready = 1'b1; dbg_addr = '0;
    idle();
    in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_use_imm = 1'b0; in_imm = '0;
    tick(); tick();
    RST = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_zero", {31'd0, out_zero}, 32'd0);
    dbg("rst_reg1", 5'd1, 32'd0);

    // Back-to-back dependent ADDs, forwarding from R
    send(3'b000, 5'd0, 5'd0, 5'd1, 1'b1, 32'd5); tick();
    send(3'b000, 5'd1, 5'd0, 5'd2, 1'b1, 32'd3); tick();
    chk("add1_valid", {31'd0, out_valid}, 32'd1);
    chk("add1_result", out_result, 32'd5);
    chk("add1_rd", {27'd0, out_rd}, 32'd1);
    idle(); tick();
    chk("add2_valid_nobubble", {31'd0, out_valid}, 32'd1);
    chk("add2_result", out_result, 32'd8);
    chk("add2_rd", {27'd0, out_rd}, 32'd2);
    dbg("wb_reg1", 5'd1, 32'd5);
    tick();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    dbg("wb_reg2", 5'd2, 32'd8);

    // ALU operation stream
    send(3'b000, 5'd0, 5'd0, 5'd3, 1'b1, 32'd3); tick();
    send(3'b001, 5'd3, 5'd0, 5'd6, 1'b1, 32'd5); tick();
    chk("ld3", out_result, 32'd3);
    send(3'b000, 5'd0, 5'd0, 5'd7, 1'b1, 32'h8000_0000); tick();
    chk("sub", out_result, 32'hFFFF_FFFE);
    chk("sub_zero", {31'd0, out_zero}, 32'd0);
    send(3'b100, 5'd7, 5'd0, 5'd8, 1'b1, 32'd36); tick();
    chk("ld7", out_result, 32'h8000_0000);
    send(3'b011, 5'd7, 5'd0, 5'd9, 1'b1, 32'd36); tick();
    chk("sra", out_result, 32'hF800_0000);
    send(3'b010, 5'd3, 5'd0, 5'd10, 1'b1, 32'd4); tick();
    chk("srl", out_result, 32'h0800_0000);
    send(3'b101, 5'd6, 5'd3, 5'd11, 1'b0, 32'd0); tick();
    chk("sll", out_result, 32'h0000_0030);
    send(3'b110, 5'd3, 5'd0, 5'd12, 1'b1, 32'h100); tick();
    chk("and_reg", out_result, 32'd2);
    send(3'b111, 5'd3, 5'd3, 5'd13, 1'b0, 32'd0); tick();
    chk("or", out_result, 32'h103);
    idle(); tick();
    chk("xor", out_result, 32'd0);
    chk("xor_zero", {31'd0, out_zero}, 32'd1);
    tick();
    dbg("wb_reg6", 5'd6, 32'hFFFF_FFFE);

    // Back-pressure with two in flight
    out_ready = 1'b0;
    send(3'b000, 5'd0, 5'd0, 5'd15, 1'b1, 32'd10); tick();
    chk("bp_in_ready_pre", {31'd0, in_ready}, 32'd1);
    send(3'b000, 5'd15, 5'd0, 5'd16, 1'b1, 32'd1); tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_result_hold", out_result, 32'd10);
      dbg("bp_no_wb", 5'd15, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_second_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_second", out_result, 32'd11);
    dbg("bp_wb15", 5'd15, 32'd10);
    tick();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);
    dbg("bp_wb16", 5'd16, 32'd11);

    // Forward from a stalled X on the release cycle
    out_ready = 1'b0;
    send(3'b000, 5'd0, 5'd0, 5'd3, 1'b1, 32'd20); tick();
    idle(); tick(); tick();
    chk("fx_stalled", out_result, 32'd20);
    out_ready = 1'b1;
    send(3'b000, 5'd3, 5'd0, 5'd17, 1'b1, 32'd2); tick();
    idle();
    chk("fx_gap", {31'd0, out_valid}, 32'd0);
    dbg("fx_wb3", 5'd3, 32'd20);
    tick();
    chk("fx_result", out_result, 32'd22);
    chk("fx_rd", {27'd0, out_rd}, 32'd17);
    tick();

    // reg[0] behaviour
`ifdef REGFILE_ZERO_REG_EN
    exp_r4 = 32'd1; exp_r0 = 32'd0;
`else
    exp_r4 = 32'd8; exp_r0 = 32'd7;
`endif
    send(3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 32'd7); tick();
    send(3'b000, 5'd0, 5'd0, 5'd4, 1'b1, 32'd1); tick();
    idle();
    chk("z_first", out_result, 32'd7);
    chk("z_first_rd", {27'd0, out_rd}, 32'd0);
    tick();
    chk("z_second", out_result, exp_r4);
    tick();
    dbg("z_reg0", 5'd0, exp_r0);

    // Reset while a write is stalled in X
    out_ready = 1'b0;
    send(3'b000, 5'd0, 5'd0, 5'd5, 1'b1, 32'd9); tick();
    idle(); tick();
    chk("mid_valid", {31'd0, out_valid}, 32'd1);
    RST = 1'b1; tick(); RST = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_result", out_result, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    dbg("mid_rst_reg5", 5'd5, 32'd0);
    dbg("mid_rst_reg2", 5'd2, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
